// File: rtl/imem_loader.sv
// imem_loader
//   Debug-unit writer for the instruction memory's program-load port. Bytes
//   arriving from the UART receiver are packed big-endian into 32-bit words,
//   and each word is written once at consecutive addresses starting from 0.
//   A load ends when a HALT word has been written or when the last address of
//   memory has been written. load_done is then held until the next start.
//
// Ports
//   clk              in   system clock, all logic on posedge
//   rst              in   synchronous active-high reset
//   start            in   1-cycle pulse, begin a new load at address 0
//   rx_data[7:0]     in   received byte
//   rx_valid         in   1-cycle strobe, rx_data valid this cycle
//   wr_instruction   out  1-cycle write strobe to instruction memory
//   data_instruction out  assembled word, held until the next word completes
//   wr_addr          out  word address of the current or next write
//   busy             out  high while receiving or writing
//   load_done        out  high once the load has finished
//   overflow         out  load finished by filling memory without a HALT word
//   word_count       out  words written in the current load
//
// wr_addr is ADDR_W bits wide and stops at DEPTH-1, so DEPTH must not exceed
// 2**ADDR_W.

module imem_loader #(
  parameter int          DEPTH     = 32,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_instruction,
  output logic [31:0]       data_instruction,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  state_t            state, state_next;
  logic [1:0]        byte_cnt, byte_cnt_next;
  // Holds the first three bytes of a word; the fourth byte goes straight
  // into data_instruction together with these.
  logic [23:0]       shift_reg, shift_next;
  logic [31:0]       data_next;
  logic [ADDR_W-1:0] addr_next, count_next;
  logic              overflow_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      byte_cnt         <= '0;
      shift_reg        <= '0;
      data_instruction <= '0;
      wr_addr          <= '0;
      word_count       <= '0;
      overflow         <= 1'b0;
    end else begin
      state            <= state_next;
      byte_cnt         <= byte_cnt_next;
      shift_reg        <= shift_next;
      data_instruction <= data_next;
      wr_addr          <= addr_next;
      word_count       <= count_next;
      overflow         <= overflow_next;
    end
  end

  always_comb begin
    state_next     = state;
    byte_cnt_next  = byte_cnt;
    shift_next     = shift_reg;
    data_next      = data_instruction;
    addr_next      = wr_addr;
    count_next     = word_count;
    overflow_next  = overflow;
    wr_instruction = 1'b0;
    busy           = 1'b0;
    load_done      = 1'b0;

    case (state)
      IDLE, DONE: begin
        load_done = (state == DONE);
        if (start) begin
          state_next    = RECV;
          addr_next     = '0;
          count_next    = '0;
          byte_cnt_next = '0;
          shift_next    = '0;
          overflow_next = 1'b0;
        end
      end

      RECV: begin
        busy = 1'b1;
        if (rx_valid) begin
          if (byte_cnt == 2'd3) begin
            data_next     = {shift_reg, rx_data};
            byte_cnt_next = '0;
            state_next    = WRITE;
          end else begin
            shift_next    = {shift_reg[15:0], rx_data};
            byte_cnt_next = byte_cnt + 2'd1;
          end
        end
      end

      WRITE: begin
        busy           = 1'b1;
        wr_instruction = 1'b1;
        count_next     = word_count + ADDR_W'(1);
        if (data_instruction == HALT_WORD) begin
          state_next    = DONE;
          overflow_next = 1'b0;
        end else if (wr_addr == LAST_ADDR) begin
          state_next    = DONE;
          overflow_next = 1'b1;
        end else begin
          state_next = RECV;
          addr_next  = wr_addr + ADDR_W'(1);
          // A byte arriving during the write cycle starts the next word
          if (rx_valid) begin
            shift_next    = {shift_reg[15:0], rx_data};
            byte_cnt_next = 2'd1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
